// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetches a word at PC, decodes it, then resolves a
// conditional branch, hands the word to the execute datapath, or halts.
module pc_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Run,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   input  logic [2:0]  cc_nzp,
   output logic        exec_valid,
   input  logic        exec_ready,
   output logic [15:0] PC,
   output logic [15:0] IR,
   output logic        branch_taken,
   output logic [15:0] instret,
   output logic        halted
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      BRANCH = 3'd3,
      EXEC   = 3'd4,
      HALT   = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] instret_q, instret_d;
   logic        branch_hit;

   function automatic logic [15:0] sext16(input logic [7:0] off);
      return {{8{off[7]}}, off};
   endfunction

   // IR[11] is deliberately left out of the condition mask.
   assign branch_hit = |(ir_q[10:8] & cc_nzp);

   // State and datapath registers; Reset overrides everything.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         ir_q      <= 16'h0000;
         instret_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         instret_q <= instret_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (Run) state_d = FETCH;
            else     state_d = IDLE;
         end
         FETCH: begin
            if (mem_ready) state_d = DECODE;
            else           state_d = FETCH;
         end
         DECODE: begin
            if (ir_q[15:12] == 4'b0000)      state_d = BRANCH;
            else if (ir_q[15:12] == 4'b1111) state_d = HALT;
            else                             state_d = EXEC;
         end
         BRANCH: begin
            if (Run) state_d = FETCH;
            else     state_d = IDLE;
         end
         EXEC: begin
            if (!exec_ready) state_d = EXEC;
            else if (Run)    state_d = FETCH;
            else             state_d = IDLE;
         end
         HALT: begin
            if (Run) state_d = HALT;
            else     state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // PC, IR and retire counter updates.
   always_comb begin
      pc_d      = pc_q;
      ir_d      = ir_q;
      instret_d = instret_q;
      case (state_q)
         FETCH: begin
            if (mem_ready) begin
               ir_d = mem_rdata;
               pc_d = pc_q + 16'd1;
            end else begin
               ir_d = ir_q;
               pc_d = pc_q;
            end
         end
         BRANCH: begin
            if (branch_hit) pc_d = pc_q + sext16(ir_q[7:0]);
            else            pc_d = pc_q;
            instret_d = instret_q + 16'd1;
         end
         EXEC: begin
            if (exec_ready) instret_d = instret_q + 16'd1;
            else            instret_d = instret_q;
         end
         default: begin
            pc_d      = pc_q;
            ir_d      = ir_q;
            instret_d = instret_q;
         end
      endcase
   end

   // Handshake outputs, forced low while Reset is asserted.
   always_comb begin
      mem_rd       = 1'b0;
      exec_valid   = 1'b0;
      branch_taken = 1'b0;
      halted       = 1'b0;
      if (!Reset) begin
         case (state_q)
            FETCH:   mem_rd       = 1'b1;
            BRANCH:  branch_taken = branch_hit;
            EXEC:    exec_valid   = 1'b1;
            HALT:    halted       = 1'b1;
            default: mem_rd       = 1'b0;
         endcase
      end else begin
         mem_rd = 1'b0;
      end
   end

   assign mem_addr = pc_q;
   assign PC       = pc_q;
   assign IR       = ir_q;
   assign instret  = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main flow plus
// hand-written sequences for HALT, Run drop, reset mid-EXEC and PC wrap.
module tb_pc_sequencer;

   logic        Clk = 1'b0;
   logic        Reset, Run, mem_ready, exec_ready;
   logic [15:0] mem_rdata;
   logic [2:0]  cc_nzp;

   logic        mem_rd, exec_valid, branch_taken, halted;
   logic [15:0] mem_addr, PC, IR, instret;
   logic        w_mem_rd, w_exec_valid, w_branch_taken, w_halted;
   logic [15:0] w_mem_addr, w_PC, w_IR, w_instret;

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   pc_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .cc_nzp(cc_nzp),
      .exec_valid(exec_valid), .exec_ready(exec_ready), .PC(PC), .IR(IR),
      .branch_taken(branch_taken), .instret(instret), .halted(halted)
   );

   pc_sequencer #(.RESET_PC(16'hFFFF)) dut_wrap (
      .Clk(Clk), .Reset(Reset), .Run(Run), .mem_rd(w_mem_rd), .mem_addr(w_mem_addr),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .cc_nzp(cc_nzp),
      .exec_valid(w_exec_valid), .exec_ready(exec_ready), .PC(w_PC), .IR(w_IR),
      .branch_taken(w_branch_taken), .instret(w_instret), .halted(w_halted)
   );

   typedef struct {
      logic        rst, run, rdy;
      logic [15:0] rdata;
      logic [2:0]  cc;
      logic        xrdy;
      logic        e_rd, e_xv, e_bt, e_h;
      logic [15:0] e_pc, e_ir, e_inst;
   } vec_t;

   vec_t vecs [24];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic run, input logic rdy,
                        input logic [15:0] rdata, input logic [2:0] cc, input logic xrdy);
      @(negedge Clk);
      Reset = rst; Run = run; mem_ready = rdy; mem_rdata = rdata;
      cc_nzp = cc; exec_ready = xrdy;
      #1;
   endtask

   initial begin
      //           rst  run  rdy  rdata     cc    xrdy  rd   xv   bt   h    pc        ir        inst
      vecs[0]  = '{1'b1,1'b0,1'b0,16'h0000,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000};
      vecs[1]  = '{1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000};
      vecs[2]  = '{1'b0,1'b1,1'b0,16'h1234,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000};
      vecs[3]  = '{1'b0,1'b1,1'b0,16'h1234,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000};
      vecs[4]  = '{1'b0,1'b1,1'b0,16'h1234,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000};
      vecs[5]  = '{1'b0,1'b1,1'b1,16'h1234,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000};
      vecs[6]  = '{1'b0,1'b1,1'b0,16'h1234,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0001,16'h1234,16'h0000};
      vecs[7]  = '{1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0001,16'h1234,16'h0000};
      vecs[8]  = '{1'b0,1'b1,1'b0,16'h0000,3'd0,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0001,16'h1234,16'h0000};
      vecs[9]  = '{1'b0,1'b1,1'b1,16'h070E,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0001,16'h1234,16'h0001};
      vecs[10] = '{1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0002,16'h070E,16'h0001};
      vecs[11] = '{1'b0,1'b1,1'b0,16'h0000,3'd1,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0002,16'h070E,16'h0001};
      vecs[12] = '{1'b0,1'b1,1'b1,16'h02FE,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0010,16'h070E,16'h0002};
      vecs[13] = '{1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0011,16'h02FE,16'h0002};
      vecs[14] = '{1'b0,1'b1,1'b0,16'h0000,3'd2,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0011,16'h02FE,16'h0002};
      vecs[15] = '{1'b0,1'b1,1'b1,16'h02FE,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h000F,16'h02FE,16'h0003};
      vecs[16] = '{1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0010,16'h02FE,16'h0003};
      vecs[17] = '{1'b0,1'b1,1'b0,16'h0000,3'd4,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0010,16'h02FE,16'h0003};
      vecs[18] = '{1'b0,1'b1,1'b1,16'h0EFE,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0010,16'h02FE,16'h0004};
      vecs[19] = '{1'b0,1'b1,1'b1,16'hFFFF,3'd0,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0011,16'h0EFE,16'h0004};
      vecs[20] = '{1'b0,1'b1,1'b1,16'hFFFF,3'd1,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0011,16'h0EFE,16'h0004};
      vecs[21] = '{1'b0,1'b1,1'b0,16'h0000,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0011,16'h0EFE,16'h0005};
      vecs[22] = '{1'b1,1'b1,1'b1,16'hAAAA,3'd7,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0011,16'h0EFE,16'h0005};
      vecs[23] = '{1'b0,1'b0,1'b0,16'h0000,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000};

      Reset = 1'b1; Run = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000;
      cc_nzp = 3'd0; exec_ready = 1'b0;
      repeat (2) @(posedge Clk);

      for (int i = 0; i < 24; i++) begin
         drive(vecs[i].rst, vecs[i].run, vecs[i].rdy, vecs[i].rdata, vecs[i].cc, vecs[i].xrdy);
         chk($sformatf("v%0d mem_rd", i),       mem_rd,       vecs[i].e_rd);
         chk($sformatf("v%0d exec_valid", i),   exec_valid,   vecs[i].e_xv);
         chk($sformatf("v%0d branch_taken", i), branch_taken, vecs[i].e_bt);
         chk($sformatf("v%0d halted", i),       halted,       vecs[i].e_h);
         chk($sformatf("v%0d PC", i),           PC,           vecs[i].e_pc);
         chk($sformatf("v%0d mem_addr", i),     mem_addr,     vecs[i].e_pc);
         chk($sformatf("v%0d IR", i),           IR,           vecs[i].e_ir);
         chk($sformatf("v%0d instret", i),      instret,      vecs[i].e_inst);
      end

      // HALT word: no retire, wait for Run=0, resume after the HALT word.
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("halt idle", halted, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 16'hF000, 3'd0, 1'b0);
      chk("halt fetch rd", mem_rd, 1'b1);
      chk("halt fetch addr", mem_addr, 16'h0000);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("halt decode IR", IR, 16'hF000);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1);
      chk("halt h1", halted, 1'b1);
      chk("halt rd", mem_rd, 1'b0);
      chk("halt instret", instret, 16'h0000);
      drive(1'b0, 1'b1, 1'b1, 16'h0000, 3'd0, 1'b0);
      chk("halt h2", halted, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("halt h3", halted, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("halt to idle", halted, 1'b0);
      chk("halt idle rd", mem_rd, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("resume rd", mem_rd, 1'b1);
      chk("resume addr", mem_addr, 16'h0001);
      chk("resume instret", instret, 16'h0000);

      // Run dropped during an EXEC stall.
      drive(1'b0, 1'b1, 1'b1, 16'h1234, 3'd0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("rundrop xv1", exec_valid, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("rundrop xv2", exec_valid, 1'b1);
      chk("rundrop inst0", instret, 16'h0000);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1);
      chk("rundrop xv3", exec_valid, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("rundrop xv off", exec_valid, 1'b0);
      chk("rundrop rd", mem_rd, 1'b0);
      chk("rundrop inst1", instret, 16'h0001);
      chk("rundrop PC", PC, 16'h0002);
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b0);
      chk("rundrop idle rd", mem_rd, 1'b0);

      // Reset during an EXEC stall abandons the instruction.
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 16'h5555, 3'd0, 1'b0);
      chk("rstx fetch addr", mem_addr, 16'h0002);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("rstx xv", exec_valid, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("rstx xv in reset", exec_valid, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1);
      chk("rstx xv after", exec_valid, 1'b0);
      chk("rstx PC", PC, 16'h0000);
      chk("rstx IR", IR, 16'h0000);
      chk("rstx instret", instret, 16'h0000);
      chk("rstx rd", mem_rd, 1'b0);

      // PC wrap on the RESET_PC=FFFF instance.
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("wrap reset PC", w_PC, 16'hFFFF);
      chk("wrap idle rd", w_mem_rd, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 16'h0705, 3'd0, 1'b0);
      chk("wrap fetch rd", w_mem_rd, 1'b1);
      chk("wrap fetch addr", w_mem_addr, 16'hFFFF);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("wrap PC after fetch", w_PC, 16'h0000);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd1, 1'b0);
      chk("wrap bt", w_branch_taken, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
      chk("wrap PC after br", w_PC, 16'h0005);
      chk("wrap instret", w_instret, 16'h0001);
      chk("wrap refetch rd", w_mem_rd, 1'b1);
      chk("wrap bt off", w_branch_taken, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port Run, input, 1, which enables instruction sequencing.
REQ-005 The block SHALL have port mem_rd, output, 1, the instruction-fetch read request.
REQ-006 The block SHALL have port mem_addr, output, 16, the fetch address, equal to PC.
REQ-007 The block SHALL have port mem_ready, input, 1, meaning mem_rdata is valid this cycle.
REQ-008 The block SHALL have port mem_rdata, input, 16, the fetched instruction word.
REQ-009 The block SHALL have port cc_nzp, input, 3, the datapath condition codes {N,Z,P}.
REQ-010 The block SHALL have port exec_valid, output, 1, meaning the instruction in IR is offered to the execute datapath.
REQ-011 The block SHALL have port exec_ready, input, 1, meaning the execute datapath has accepted or completed the instruction.
REQ-012 The block SHALL have port PC, output, 16, the program counter.
REQ-013 The block SHALL have port IR, output, 16, the instruction register.
REQ-014 The block SHALL have port branch_taken, output, 1, a single-cycle indication that a branch redirected PC.
REQ-015 The block SHALL have port instret, output, 16, the count of retired instructions.
REQ-016 The block SHALL have port halted, output, 1, high while in HALT.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, FETCH, DECODE, BRANCH, EXEC and HALT.
REQ-018 IDLE: all handshake outputs low; go to FETCH when Run=1, otherwise stay.
REQ-019 FETCH: mem_rd=1, mem_addr=PC; mem_ready is sampled only in FETCH and ignored in every other state.
REQ-020 FETCH: while mem_ready=0, stay in FETCH with PC and IR held.
REQ-021 FETCH: when mem_ready=1, IR<=mem_rdata, PC<=PC+1 (mod 2^16), go to DECODE.
REQ-022 Fetch latency SHALL be one cycle after mem_ready, i.e. the minimum is FETCH(1) + DECODE(1).
REQ-023 DECODE, lasting one cycle, SHALL go to BRANCH when IR[15:12]=4'b0000, to HALT when IR[15:12]=4'b1111, and to EXEC otherwise.
REQ-024 BRANCH, lasting one cycle, SHALL evaluate taken = |(IR[10:8] & cc_nzp) using the cc_nzp value sampled in that cycle.
REQ-025 When the branch is taken, PC<=PC+sext16(IR[7:0]), where sext16 replicates IR[7] into bits 15:8; the addition SHALL be unsigned mod 2^16, so wrap-around in either direction is legal.
REQ-026 branch_taken SHALL be combinational and high only in a BRANCH cycle with taken=1; when not taken, PC SHALL be unchanged.
REQ-027 IR[11] SHALL be ignored.
REQ-028 When IR[10:8]=000 or cc_nzp=000, the branch SHALL never be taken.
REQ-029 EXEC: exec_valid=1 every cycle in EXEC; stay in EXEC while exec_ready=0.
REQ-030 EXEC: when exec_ready=1, the instruction retires.
REQ-031 exec_ready outside EXEC SHALL be ignored.
REQ-032 On leaving BRANCH, or on retiring from EXEC, instret SHALL increment by 1 (wraps 16'hFFFF->16'h0000).
REQ-033 On leaving BRANCH or retiring from EXEC, the next state SHALL be FETCH if Run=1 and IDLE if Run=0.
REQ-034 Run=0 in FETCH, DECODE, BRANCH or EXEC SHALL NOT abort the current instruction; it is honored only at the retire boundary.
REQ-035 HALT: halted=1, and the HALT instruction SHALL NOT increment instret.
REQ-036 HALT SHALL stay while Run=1 and go to IDLE when Run=0.
REQ-037 A fresh Run=1 from IDLE SHALL resume fetch at the current PC, which already points past the HALT word.
REQ-038 PC SHALL change only on a FETCH handshake, a taken branch, or reset.
REQ-039 IR SHALL change only on a FETCH handshake or reset.

Reset
REQ-040 Reset SHALL take priority over every other input in every state, including mid-FETCH and mid-EXEC.
REQ-041 On Reset: state<=IDLE, PC<=RESET_PC, IR<=16'h0000, instret<=16'h0000.
REQ-042 While in reset, and in the first cycle after reset, mem_rd=0, exec_valid=0, branch_taken=0 and halted=0.
REQ-043 A pending memory or execute handshake SHALL be abandoned on reset, with no retire counted.

Verification
REQ-044 Reset then Run=1, mem_rdata=16'h1234 with mem_ready delayed 3 cycles: mem_rd high 4 cycles at mem_addr=0000, then IR=1234 and PC=0001; exec_valid asserts 2 cycles after mem_ready; exec_ready=1 gives instret=1 and a new fetch at 0001.
REQ-045 PC=0010 fetches 16'h02FE (BR z, offset -2) with cc_nzp=010: branch_taken pulses once and PC=0011-2=000F; with cc_nzp=100 instead, PC=0011 and branch_taken stays 0.
REQ-046 Wrap-around: RESET_PC=16'hFFFF fetches 16'h0705 with cc_nzp=001: the fetch gives PC=0000, the branch gives PC=0005, and instret=1.
REQ-047 Fetch 16'hF000 with Run held at 1: halted=1 and instret is unchanged; Run=0 goes to IDLE; Run=1 again fetches at the address after the HALT word.
REQ-048 Reset asserted during EXEC with exec_ready=0: next cycle state is IDLE, PC=RESET_PC, instret=0 and exec_valid=0.
REQ-049 Run dropped during an EXEC stall: exec_valid is held until exec_ready, the instruction retires, then IDLE with no further mem_rd.
